// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 encodings,
// access-size decode and the alignment rules used by load_store_unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsuState_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } accessSize_t;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    localparam int LSU_DEFAULT_TIMEOUT = 255;

    // Any encoding outside the byte/half family behaves as a full word.
    function automatic accessSize_t sizeOf(input logic [2:0] funct3);
        case (funct3)
            F3_BYTE, F3_BYTEU: sizeOf = SIZE_BYTE;
            F3_HALF, F3_HALFU: sizeOf = SIZE_HALF;
            default:           sizeOf = SIZE_WORD;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (sizeOf(funct3))
            SIZE_BYTE: isMisaligned = 1'b0;
            SIZE_HALF: isMisaligned = offset[0];
            default:   isMisaligned = (offset != 2'b00);
        endcase
    endfunction

    // Clears the low address bits that would straddle the access size.
    function automatic logic [1:0] forceAligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (sizeOf(funct3))
            SIZE_BYTE: forceAligned = offset;
            SIZE_HALF: forceAligned = {offset[1], 1'b0};
            default:   forceAligned = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store-side byte enables and lane replication,
// load-side lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  storeFunct3,
    input  logic [1:0]  storeOffset,
    input  logic [31:0] storeData,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadOffset,
    input  logic [31:0] loadWord,
    output logic [3:0]  byteEnable,
    output logic [31:0] storeLanes,
    output logic [31:0] loadResult
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        byteEnable = 4'b1111;
        storeLanes = storeData;
        case (sizeOf(storeFunct3))
            SIZE_BYTE: begin
                byteEnable = 4'b0001 << storeOffset;
                storeLanes = {4{storeData[7:0]}};
            end
            SIZE_HALF: begin
                byteEnable = 4'b0011 << {storeOffset[1], 1'b0};
                storeLanes = {2{storeData[15:0]}};
            end
            default: begin
                byteEnable = 4'b1111;
                storeLanes = storeData;
            end
        endcase
    end

    // Lane select happens before extension so the sign bit comes from the chosen lane.
    always_comb begin
        loadByte   = loadWord[{loadOffset, 3'b000} +: 8];
        loadHalf   = loadWord[{loadOffset[1], 4'b0000} +: 16];
        loadResult = loadWord;
        case (loadFunct3)
            F3_BYTE:  loadResult = {{24{loadByte[7]}}, loadByte};
            F3_BYTEU: loadResult = {24'b0, loadByte};
            F3_HALF:  loadResult = {{16{loadHalf[15]}}, loadHalf};
            F3_HALFU: loadResult = {16'b0, loadHalf};
            default:  loadResult = loadWord;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access per M-stage instruction via IDLE -> REQ -> DONE.
// Macro LSU_MISALIGN_CHK_EN turns misaligned half/word accesses into a flagged no-op.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUresultM,
    input  logic [31:0] writedataM,
    output logic [31:0] readDataM,
    output logic        StallLSU,
    output logic        LsuErrM,
    output logic        LsuMisalignM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsuState_t   state, nextState;
    logic        accessReq;
    logic        misaligned;
    logic        timeoutHit;
    logic [1:0]  reqOffset;
    logic [2:0]  capFunct3;
    logic [1:0]  capOffset;
    logic [7:0]  timeoutCount;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic [31:0] alignLoad;

    assign accessReq = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_CHK_EN
    assign misaligned = isMisaligned(funct3M, ALUresultM[1:0]);
    assign reqOffset  = ALUresultM[1:0];
`else
    assign misaligned = 1'b0;
    assign reqOffset  = forceAligned(funct3M, ALUresultM[1:0]);
`endif

    assign timeoutHit = (state == REQ) && !mem_ready && (timeoutCount == TIMEOUT_LAST);
    assign mem_req    = (state == REQ);

    lsu_align uAlign (
        .storeFunct3 (funct3M),
        .storeOffset (reqOffset),
        .storeData   (writedataM),
        .loadFunct3  (capFunct3),
        .loadOffset  (capOffset),
        .loadWord    (mem_rdata),
        .byteEnable  (alignBe),
        .storeLanes  (alignWdata),
        .loadResult  (alignLoad)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // mem_ready wins over an expiring timeout because it is tested first.
    always_comb begin
        nextState = state;
        StallLSU  = 1'b0;
        case (state)
            IDLE: begin
                StallLSU = accessReq;
                if (accessReq) nextState = misaligned ? DONE : REQ;
            end
            REQ: begin
                StallLSU = 1'b1;
                if (mem_ready || timeoutHit) nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_be       <= 4'b0000;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            readDataM    <= 32'h0;
            LsuErrM      <= 1'b0;
            LsuMisalignM <= 1'b0;
            timeoutCount <= 8'h0;
            capFunct3    <= 3'b000;
            capOffset    <= 2'b00;
        end else begin
            LsuErrM      <= 1'b0;
            LsuMisalignM <= 1'b0;
            case (state)
                IDLE: begin
                    if (accessReq && misaligned) begin
                        LsuMisalignM <= 1'b1;
                    end else if (accessReq) begin
                        mem_we       <= MemWriteM;
                        mem_be       <= alignBe;
                        mem_addr     <= {ALUresultM[31:2], 2'b00};
                        mem_wdata    <= alignWdata;
                        capFunct3    <= funct3M;
                        capOffset    <= reqOffset;
                        timeoutCount <= 8'h0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!mem_we) readDataM <= alignLoad;
                    end else begin
                        timeoutCount <= timeoutCount + 8'h1;
                        if (timeoutHit) begin
                            LsuErrM   <= 1'b1;
                            readDataM <= 32'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4); expectations adapt to LSU_MISALIGN_CHK_EN.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clock;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUresultM;
    logic [31:0] writedataM;
    logic [31:0] readDataM;
    logic        StallLSU;
    logic        LsuErrM;
    logic        LsuMisalignM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int reqCycles;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .funct3M      (funct3M),
        .ALUresultM   (ALUresultM),
        .writedataM   (writedataM),
        .readDataM    (readDataM),
        .StallLSU     (StallLSU),
        .LsuErrM      (LsuErrM),
        .LsuMisalignM (LsuMisalignM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUresultM = addr;
        writedataM = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One zero-wait access: IDLE cycle, single REQ cycle, DONE cycle with the request still asserted.
    task automatic runAccess(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] expAddr,
                             input logic [3:0] expBe, input logic [31:0] expWdata, input logic [31:0] expRead);
        @(negedge clock);
        applyStimulus(rd, wr, f3, addr, wd);
        #1;
        checkOutput({name, " idle stall"}, 32'(StallLSU), 32'd1);
        checkOutput({name, " idle req"}, 32'(mem_req), 32'd0);
        @(negedge clock);
        checkOutput({name, " req"}, 32'(mem_req), 32'd1);
        checkOutput({name, " req stall"}, 32'(StallLSU), 32'd1);
        checkOutput({name, " addr"}, mem_addr, expAddr);
        checkOutput({name, " be"}, 32'(mem_be), 32'(expBe));
        checkOutput({name, " we"}, 32'(mem_we), 32'(wr));
        checkOutput({name, " wdata"}, mem_wdata, expWdata);
        @(negedge clock);
        checkOutput({name, " done req"}, 32'(mem_req), 32'd0);
        checkOutput({name, " done stall"}, 32'(StallLSU), 32'd0);
        checkOutput({name, " readData"}, readDataM, expRead);
        checkOutput({name, " err"}, 32'(LsuErrM), 32'd0);
        checkOutput({name, " misalign"}, 32'(LsuMisalignM), 32'd0);
        @(negedge clock);
        checkOutput({name, " back idle"}, 32'(mem_req), 32'd0);
        applyStimulus(1'b0, 1'b0, F3_WORD, 32'h0, 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h80FF0011;
        applyStimulus(1'b0, 1'b0, F3_WORD, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_be", 32'(mem_be), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset readDataM", readDataM, 32'h0);
        checkOutput("reset LsuErrM", 32'(LsuErrM), 32'd0);
        checkOutput("reset LsuMisalignM", 32'(LsuMisalignM), 32'd0);
        checkOutput("reset StallLSU", 32'(StallLSU), 32'd0);
        reset = 1'b0;

        runAccess("SW",  1'b0, 1'b1, F3_WORD,  32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
        runAccess("LB",  1'b1, 1'b0, F3_BYTE,  32'h103, 32'h0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        runAccess("LBU", 1'b1, 1'b0, F3_BYTEU, 32'h103, 32'h0, 32'h100, 4'b1000, 32'h0, 32'h00000080);
        runAccess("SH",  1'b0, 1'b1, F3_HALF,  32'h202, 32'h00001234, 32'h200, 4'b1100, 32'h12341234, 32'h00000080);
        runAccess("LH",  1'b1, 1'b0, F3_HALF,  32'h102, 32'h0, 32'h100, 4'b1100, 32'h0, 32'hFFFF80FF);
        runAccess("LHU", 1'b1, 1'b0, F3_HALFU, 32'h100, 32'h0, 32'h100, 4'b0011, 32'h0, 32'h00000011);
        runAccess("SB",  1'b0, 1'b1, F3_BYTE,  32'h301, 32'h000000A5, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h00000011);
        runAccess("LX",  1'b1, 1'b0, 3'b011,   32'h104, 32'h0, 32'h104, 4'b1111, 32'h0, 32'h80FF0011);

        mem_rdata = 32'h11223344;
`ifdef LSU_MISALIGN_CHK_EN
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, F3_WORD, 32'h101, 32'h0);
        #1;
        checkOutput("MIS idle stall", 32'(StallLSU), 32'd1);
        checkOutput("MIS idle req", 32'(mem_req), 32'd0);
        @(negedge clock);
        checkOutput("MIS done req", 32'(mem_req), 32'd0);
        checkOutput("MIS pulse", 32'(LsuMisalignM), 32'd1);
        checkOutput("MIS readData", readDataM, 32'h80FF0011);
        checkOutput("MIS done stall", 32'(StallLSU), 32'd0);
        @(negedge clock);
        checkOutput("MIS pulse end", 32'(LsuMisalignM), 32'd0);
        checkOutput("MIS after req", 32'(mem_req), 32'd0);
        applyStimulus(1'b0, 1'b0, F3_WORD, 32'h0, 32'h0);
`else
        runAccess("LWMIS", 1'b1, 1'b0, F3_WORD, 32'h101, 32'h0, 32'h100, 4'b1111, 32'h0, 32'h11223344);
`endif

        // mem_ready held low: four REQ cycles, then error pulse and zeroed result.
        @(negedge clock);
        mem_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, F3_WORD, 32'h400, 32'h0);
        reqCycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!mem_req) break;
            reqCycles++;
        end
        checkOutput("TO req cycles", 32'(reqCycles), 32'd4);
        checkOutput("TO err pulse", 32'(LsuErrM), 32'd1);
        checkOutput("TO readData", readDataM, 32'h0);
        checkOutput("TO done stall", 32'(StallLSU), 32'd0);
        @(negedge clock);
        checkOutput("TO err end", 32'(LsuErrM), 32'd0);
        applyStimulus(1'b0, 1'b0, F3_WORD, 32'h0, 32'h0);

        // Ready arrives on the very cycle the counter would expire.
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, F3_WORD, 32'h404, 32'h0);
        repeat (4) @(negedge clock);
        checkOutput("RACE still req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        @(negedge clock);
        checkOutput("RACE no err", 32'(LsuErrM), 32'd0);
        checkOutput("RACE readData", readDataM, 32'h11223344);
        checkOutput("RACE done req", 32'(mem_req), 32'd0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, F3_WORD, 32'h0, 32'h0);

        // Reset during the second REQ cycle abandons the access.
        mem_ready = 1'b0;
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, F3_WORD, 32'h500, 32'h0);
        repeat (2) @(negedge clock);
        checkOutput("RST pre req", 32'(mem_req), 32'd1);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, F3_WORD, 32'h0, 32'h0);
        #1;
        checkOutput("RST req drop", 32'(mem_req), 32'd0);
        checkOutput("RST stall", 32'(StallLSU), 32'd0);
        checkOutput("RST be", 32'(mem_be), 32'd0);
        checkOutput("RST readData", readDataM, 32'h0);
        @(negedge clock);
        reset     = 1'b0;
        mem_ready = 1'b1;

        runAccess("LWPOST", 1'b1, 1'b0, F3_WORD, 32'h600, 32'h0, 32'h600, 4'b1111, 32'h0, 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
